mem_copy_engine: RTL
====================

# mem_copy_engine

Block-copy initiator for the shared single-cycle RAM. It drives the RAM's read-only and write-only ports as their master, moving `len` consecutive words from `src` to `dst` at one word per clock once the pipeline is primed. It sits beside the CPU on the RAM ports, behind an external arbiter, and is used to refresh the memory-mapped output words at addresses 0–2 and to relocate buffers.

## Interface
- `ADDR_W`, default 16: RAM address width.
- `DATA_W`, default 16: RAM word width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src`, `dst`  in  ADDR_W  first source and destination addresses; latched on accepted `start`.
- `len`  in  ADDR_W  word count; latched on accepted `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `ro_port_enable`  out  1  RAM read strobe.
- `ro_port_address`  out  ADDR_W  RAM read address.
- `ro_port_value`  in  DATA_W  RAM read data, registered, valid the cycle after the strobe.
- `wo_port_enable`  out  1  RAM write strobe.
- `wo_port_address`  out  ADDR_W  RAM write address.
- `wo_port_value`  out  DATA_W  RAM write data.

## Operation
- States: IDLE, PRIME, STREAM, FINISH.
- IDLE:
  - `start`=1 and `len`≠0: latch the operands, go to PRIME.
  - `start`=1 and `len`=0: go to FINISH. No RAM access is made.
  - `start` outside IDLE is ignored; it is neither queued nor counted as an error.
- Direction is chosen at latch time:
  - `dst` > `src`: descending. Word index runs `len-1` down to 0, so overlapping copies stay correct.
  - Otherwise: ascending.
- PRIME: issue the read of the first word, go to STREAM.
- STREAM, each cycle:
  - Write the previous read's data to the matching `dst` address.
  - If words remain, issue the next read.
  - After the write of the last word, go to FINISH.
- FINISH: pulse `done`, return to IDLE.
- Address arithmetic is `src`/`dst` ± index, modulo 2^ADDR_W; it wraps silently. No range check against RAM depth.
- The RAM returns the old value on a same-address read/write in one cycle. The direction rule guarantees this case never occurs within a transfer.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-transfer: all outputs drop immediately (asynchronously). The in-flight write is abandoned, no `done` is issued, and a partial copy remains in RAM.
- `start` at edge T, `len`=N≥1:
  - T+1: `busy` rises; read of word 0 is issued.
  - T+2 … T+N+1: write k is issued at T+2+k.
  - T+1 … T+N: reads are issued.
  - T+N+2: `done`=1, `busy`=0.
- Throughput: one word per clock. Total latency N+2 cycles.
- `len`=0: `done` at T+1. `busy` stays 0.
- Back-to-back: `start` may be asserted in the same cycle `done` is high; IDLE is reached at that edge, so the request is accepted.
- `ro_port_enable` and `wo_port_enable` are high only on cycles with a real access.

## Configuration
- Macro: `MEM_COPY_FILL_EN`.
- Defined:
  - Adds input `fill_mode` (1 bit) and input `fill_value` (DATA_W), both latched on `start`.
  - With `fill_mode`=1 there is no PRIME state and no reads. Writes of `fill_value` to `dst`…`dst+len-1` (ascending) occur at T+1 … T+N, and `done` pulses at T+N+1.
- Not defined: neither port exists; copy only.

## Structure
- Package `mem_copy_pkg` holds:
  - the state enum (IDLE/PRIME/STREAM/FINISH);
  - the direction typedef (ASC/DESC);
  - default `ADDR_W`/`DATA_W` constants.
- Sub-module `mem_copy_addr_gen`: index counter plus ± offset adder producing the read and write addresses. It is instanced once; its write index is delayed one cycle from the read index.

## Test plan
- Ascending copy: RAM[10..13]=A,B,C,D; `src`=10, `dst`=20, `len`=4 → RAM[20..23]=A,B,C,D; `done` at T+6; 4 reads and 4 writes, no extra strobes.
- Overlap descending: RAM[5..8]=1,2,3,4; `src`=5, `dst`=6, `len`=4 → RAM[6..9]=1,2,3,4; read addresses 8,7,6,5.
- Zero length: `len`=0 → `done` at T+1; `busy` never high; no strobes.
- Mid-transfer reset and ignored start: `len`=8, assert `rst` at T+4 → outputs 0 at once, no `done`; after release, a new copy completes normally. Separately, a second `start` while `busy` is ignored.
- Back-to-back and wrap-around: `start` on the `done` cycle → the second copy begins the next cycle. Separately, `src`=0xFFFE, `len`=3 → reads 0xFFFE, 0xFFFF, 0x0000.
- Fill (with `MEM_COPY_FILL_EN` defined): `fill_value`=0x00FF, `dst`=0, `len`=3 → RAM[0..2]=0x00FF; output words update; `done` at T+4.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and defaults for the memory block-copy engine.
package mem_copy_pkg;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StStream,
        StFinish
    } state_e;

    typedef enum logic {
        DirAsc,
        DirDesc
    } dir_e;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Address generator for the copy engine: one word-index counter plus base
// offset adders. The write index trails the read index by one step, which
// matches the one-cycle read latency of the RAM.
module mem_copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  dir_e              load_dir,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic              step,
    input  logic              wr_from_rd,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    dir_e              dir_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic [ADDR_W-1:0] wr_idx_q;

    // Index counter: preset on load, advance on each issued read (or fill write)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q    <= DirAsc;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
        end else if (load) begin
            dir_q    <= load_dir;
            rd_idx_q <= (load_dir == DirDesc) ? len - ADDR_W'(1) : '0;
            wr_idx_q <= '0;
        end else if (step) begin
            rd_idx_q <= (dir_q == DirDesc) ? rd_idx_q - ADDR_W'(1) : rd_idx_q + ADDR_W'(1);
            wr_idx_q <= rd_idx_q;
        end
    end

    // Base plus index, wrapping modulo 2^ADDR_W
    always_comb begin
        rd_addr = src_base + rd_idx_q;
        wr_addr = dst_base + (wr_from_rd ? rd_idx_q : wr_idx_q);
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the shared single-cycle RAM. Streams len words
// from src to dst at one word per clock after a one-cycle prime. Copies run
// descending when dst > src so overlapping moves stay correct.
// Optional fill mode is compiled in with MEM_COPY_FILL_EN.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              ro_port_enable,
    output logic [ADDR_W-1:0] ro_port_address,
    input  logic [DATA_W-1:0] ro_port_value,
    output logic              wo_port_enable,
    output logic [ADDR_W-1:0] wo_port_address,
    output logic [DATA_W-1:0] wo_port_value
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] reads_left_q, reads_left_d;
    logic [ADDR_W-1:0] writes_left_q, writes_left_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic              accept, load, fill_start;
    logic              rd_en, wr_en, step;
    dir_e              load_dir;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    // FINISH behaves like IDLE for a new request so back-to-back starts are taken
    assign accept = start && (state_q == StIdle || state_q == StFinish);
    assign load   = accept && (len != '0);

`ifdef MEM_COPY_FILL_EN
    assign fill_start = fill_mode;

    // Fill operands are latched alongside the copy operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (load) begin
            fill_q     <= fill_mode;
            fill_val_q <= fill_value;
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_q     = 1'b0;
    assign fill_val_q = '0;
`endif

    // Fill always walks ascending; copies go descending only when dst is above src
    assign load_dir = (fill_start || !(dst > src)) ? DirAsc : DirDesc;

    // State and operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            reads_left_q  <= '0;
            writes_left_q <= '0;
            src_q         <= '0;
            dst_q         <= '0;
        end else begin
            state_q       <= state_d;
            reads_left_q  <= reads_left_d;
            writes_left_q <= writes_left_d;
            if (load) begin
                src_q <= src;
                dst_q <= dst;
            end
        end
    end

    // Next-state logic and RAM strobes
    always_comb begin
        state_d       = state_q;
        reads_left_d  = reads_left_q;
        writes_left_d = writes_left_q;
        busy          = 1'b0;
        done          = 1'b0;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
        step          = 1'b0;
        unique case (state_q)
            StIdle, StFinish: begin
                done    = (state_q == StFinish);
                state_d = StIdle;
                if (accept) begin
                    if (len == '0) begin
                        state_d = StFinish;
                    end else begin
                        reads_left_d  = len;
                        writes_left_d = len;
                        state_d       = fill_start ? StStream : StPrime;
                    end
                end
            end
            StPrime: begin
                busy         = 1'b1;
                rd_en        = 1'b1;
                step         = 1'b1;
                reads_left_d = reads_left_q - ADDR_W'(1);
                state_d      = StStream;
            end
            StStream: begin
                busy          = 1'b1;
                wr_en         = 1'b1;
                writes_left_d = writes_left_q - ADDR_W'(1);
                if (fill_q) begin
                    step = 1'b1;
                end else if (reads_left_q != '0) begin
                    rd_en        = 1'b1;
                    step         = 1'b1;
                    reads_left_d = reads_left_q - ADDR_W'(1);
                end
                if (writes_left_q == ADDR_W'(1)) begin
                    state_d = StFinish;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    mem_copy_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_dir   (load_dir),
        .len        (len),
        .src_base   (src_q),
        .dst_base   (dst_q),
        .step       (step),
        .wr_from_rd (fill_q),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr)
    );

    // Port outputs are held at zero whenever the strobe is low
    always_comb begin
        ro_port_enable  = rd_en;
        ro_port_address = rd_en ? rd_addr : '0;
        wo_port_enable  = wr_en;
        wo_port_address = wr_en ? wr_addr : '0;
        wo_port_value   = '0;
        if (wr_en) begin
            wo_port_value = fill_q ? fill_val_q : ro_port_value;
        end
    end

endmodule
